// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and defaults for the write buffer
package wb_pkg;

  // Byte [0] is the most significant byte of the word.
  typedef logic [0:3][7:0] word_bytes_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } wb_state_t;

  localparam int DEFAULT_DEPTH      = 4;
  localparam int DEFAULT_MEM_CYCLES = 4;

endpackage

// File: rtl/write_buffer_if.sv
// rtl/write_buffer_if.sv - cache-side and memory-side signal bundle of the write buffer
interface write_buffer_if;
  import wb_pkg::*;

  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_addr;
  word_bytes_t wr_data;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_valid;
  word_bytes_t rd_data;
  logic [31:0] mem_addr;
  word_bytes_t mem_data_in;
  word_bytes_t mem_data_out;
  logic        mem_write_en;
  logic        empty;

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_req, rd_addr, mem_data_out,
    output wr_ready, rd_valid, rd_data, mem_addr, mem_data_in, mem_write_en, empty
  );

  modport master (
    output wr_valid, wr_addr, wr_data, rd_req, rd_addr, mem_data_out,
    input  wr_ready, rd_valid, rd_data, mem_addr, mem_data_in, mem_write_en, empty
  );

endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - store entry FIFO with youngest-match word address lookup
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic                       push,
  input  logic [29:0]                push_word,
  input  word_bytes_t                push_data,
  input  logic                       pop,
  output logic [29:0]                head_word,
  output word_bytes_t                head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic [29:0]                lookup_word,
  output logic                       lookup_hit,
  output word_bytes_t                lookup_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [29:0]   addr_mem [DEPTH];
  word_bytes_t   data_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] idx;

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= push_word;
      data_mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_word = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  // Walk oldest to youngest so the last valid match wins.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    idx         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if ((CW'(i) < count) && (addr_mem[idx] == lookup_word)) begin
        lookup_hit  = 1'b1;
        lookup_data = data_mem[idx];
      end
    end
  end

endmodule

// File: rtl/write_buffer.sv
// rtl/write_buffer.sv - store buffer with read forwarding in front of a slow main memory
module write_buffer
  import wb_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int MEM_CYCLES = DEFAULT_MEM_CYCLES
) (
  input  logic          clk,
  input  logic          rst_b,
  write_buffer_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);

  wb_state_t     state;
  wb_state_t     state_nx;
  logic [3:0]    cyc;
  logic [3:0]    cyc_nx;
  logic [CW-1:0] count;
  logic [29:0]   head_word;
  word_bytes_t   head_data;
  logic          lookup_hit;
  word_bytes_t   lookup_data;
  logic          wr_ready_c;
  logic          push;
  logic          pop;
  logic          last_cyc;
  logic          rd_take;
  logic          rd_hit;
  logic          rd_miss;
  logic          start_read;
  logic          rd_pend;
  logic [29:0]   rd_word_q;
  logic          rd_valid_q;
  word_bytes_t   rd_data_q;
  logic          mem_we;
  logic [31:0]   mem_addr_c;
  word_bytes_t   mem_data_c;
  logic          addr_lsbs_unused;

  assign addr_lsbs_unused = ^{bus.wr_addr[1:0], bus.rd_addr[1:0]};

  assign wr_ready_c = count < CW'(DEPTH);
  assign push       = bus.wr_valid && wr_ready_c;
  assign last_cyc   = cyc == 4'(MEM_CYCLES - 1);
  // Only one read in flight: a pending or active read masks new requests.
  assign rd_take    = bus.rd_req && !rd_pend && (state != ST_READ);
  assign rd_hit     = rd_take && lookup_hit;
  assign rd_miss    = rd_take && !lookup_hit;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_b       (rst_b),
    .push        (push),
    .push_word   (bus.wr_addr[31:2]),
    .push_data   (bus.wr_data),
    .pop         (pop),
    .head_word   (head_word),
    .head_data   (head_data),
    .count       (count),
    .lookup_word (bus.rd_addr[31:2]),
    .lookup_hit  (lookup_hit),
    .lookup_data (lookup_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state <= ST_IDLE;
      cyc   <= '0;
    end else begin
      state <= state_nx;
      cyc   <= cyc_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cyc_nx     = cyc;
    pop        = 1'b0;
    start_read = 1'b0;
    mem_we     = 1'b0;
    mem_addr_c = '0;
    mem_data_c = '0;
    case (state)
      ST_IDLE: begin
        cyc_nx = '0;
        if (rd_pend || rd_miss) begin
          state_nx   = ST_READ;
          start_read = 1'b1;
        end else if ((count != '0) || push) begin
          state_nx = ST_WRITE;
        end
      end
      ST_WRITE: begin
        mem_we     = 1'b1;
        mem_addr_c = {head_word, 2'b00};
        mem_data_c = head_data;
        cyc_nx     = cyc + 4'd1;
        if (last_cyc) begin
          pop      = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      ST_READ: begin
        mem_addr_c = {rd_word_q, 2'b00};
        cyc_nx     = cyc + 4'd1;
        if (last_cyc) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      rd_pend    <= 1'b0;
      rd_word_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      if (rd_hit) begin
        rd_valid_q <= 1'b1;
        rd_data_q  <= lookup_data;
      end
      if ((state == ST_READ) && last_cyc) begin
        rd_valid_q <= 1'b1;
        rd_data_q  <= bus.mem_data_out;
      end
      if (rd_miss) rd_word_q <= bus.rd_addr[31:2];
      if (start_read)   rd_pend <= 1'b0;
      else if (rd_miss) rd_pend <= 1'b1;
    end
  end

  assign bus.wr_ready     = wr_ready_c;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.mem_write_en = mem_we;
  assign bus.mem_addr     = mem_addr_c;
  assign bus.mem_data_in  = mem_data_c;
  assign bus.empty        = (count == '0) && (state != ST_WRITE);

endmodule

// File: tb/tb_write_buffer.sv
// tb/tb_write_buffer.sv - directed and randomized checks of write_buffer against a queue model
module tb_write_buffer;
  import wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int MEMC  = 4;

  logic clk   = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  write_buffer_if bus();

  write_buffer #(.DEPTH(DEPTH), .MEM_CYCLES(MEMC)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus.slave)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'h5A3C_96E1;
  endfunction

  function automatic logic [31:0] al(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  assign bus.mem_data_out = mem_fn(bus.mem_addr);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stores plus a countdown for the memory access in progress.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  int          m_busy   = 0;
  logic        m_is_wr  = 1'b0;
  logic [31:0] m_raddr  = '0;
  logic        m_pend   = 1'b0;
  logic [31:0] m_paddr  = '0;
  logic        m_rdv    = 1'b0;
  logic [31:0] m_rdd    = '0;
  logic        model_on = 1'b0;

  task automatic compare();
    logic        we;
    logic [31:0] ea;
    logic [31:0] ed;
    we = (m_busy > 0) && m_is_wr;
    ea = '0;
    ed = '0;
    if (m_busy > 0) ea = m_is_wr ? al(mq[0].addr) : al(m_raddr);
    if (we) ed = mq[0].data;
    chk("model_wr_ready", bus.wr_ready, mq.size() < DEPTH);
    chk("model_empty", bus.empty, (mq.size() == 0) && !we);
    chk("model_mem_write_en", bus.mem_write_en, we);
    chk("model_mem_addr", bus.mem_addr, ea);
    chk("model_mem_data_in", bus.mem_data_in, ed);
    chk("model_rd_valid", bus.rd_valid, m_rdv);
    if (m_rdv) chk("model_rd_data", bus.rd_data, m_rdd);
  endtask

  task automatic step_model();
    logic        push_ok;
    logic        rd_acc;
    logic        hit;
    logic        miss;
    logic        nv;
    logic [31:0] nd;
    if (!rst_b) begin
      mq.delete();
      m_busy   = 0;
      m_pend   = 1'b0;
      m_rdv    = 1'b0;
      model_on = 1'b1;
      return;
    end
    push_ok = bus.wr_valid && (mq.size() < DEPTH);
    rd_acc  = bus.rd_req && !m_pend && !((m_busy > 0) && !m_is_wr);
    hit = 1'b0;
    nd  = m_rdd;
    if (rd_acc) begin
      foreach (mq[i]) begin
        if (mq[i].addr[31:2] == bus.rd_addr[31:2]) begin
          hit = 1'b1;
          nd  = mq[i].data;
        end
      end
    end
    nv   = hit;
    miss = rd_acc && !hit;
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        if (m_is_wr) void'(mq.pop_front());
        else begin
          nv = 1'b1;
          nd = mem_fn(al(m_raddr));
        end
      end
      if (miss) begin
        m_pend  = 1'b1;
        m_paddr = bus.rd_addr;
      end
    end else if (m_pend || miss) begin
      m_is_wr = 1'b0;
      m_raddr = m_pend ? m_paddr : bus.rd_addr;
      m_pend  = 1'b0;
      m_busy  = MEMC;
    end else if ((mq.size() > 0) || push_ok) begin
      m_is_wr = 1'b1;
      m_busy  = MEMC;
    end
    if (push_ok) mq.push_back('{addr: bus.wr_addr, data: bus.wr_data});
    m_rdv = nv;
    m_rdd = nd;
  endtask

  always @(negedge clk) begin
    if (model_on) compare();
    step_model();
  end

  logic [31:0] wr_log[$];
  logic        prev_we = 1'b0;
  always @(negedge clk) begin
    if (bus.mem_write_en && !prev_we) wr_log.push_back(bus.mem_addr);
    prev_we = bus.mem_write_en;
  end

  task automatic drive(input logic rb, input logic wv, input logic [31:0] wa,
                       input logic [31:0] wd, input logic rq, input logic [31:0] ra);
    @(posedge clk);
    #1;
    rst_b        = rb;
    bus.wr_valid = wv;
    bus.wr_addr  = wa;
    bus.wr_data  = wd;
    bus.rd_req   = rq;
    bus.rd_addr  = ra;
    #2;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, 1'b1, a, d, 1'b0, '0);
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 100 && !bus.empty; i++) idle();
    chk(name, bus.empty, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          k;
    int          refused_at;
    int          acc_at[5];
    logic [31:0] a5[5];
    logic [31:0] d5[5];
    logic        wv;
    logic        rq;
    logic        rb;
    logic [31:0] wa;
    logic [31:0] ra;

    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rd_req   = 1'b0;
    bus.rd_addr  = '0;

    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    idle();
    chk("reset_empty", bus.empty, 1'b1);
    chk("reset_wr_ready", bus.wr_ready, 1'b1);
    chk("reset_mem_write_en", bus.mem_write_en, 1'b0);
    chk("reset_mem_addr", bus.mem_addr, 32'h0);
    chk("reset_mem_data_in", bus.mem_data_in, 32'h0);
    chk("reset_rd_valid", bus.rd_valid, 1'b0);
    chk("reset_rd_data", bus.rd_data, 32'h0);

    // Single store drains in MEMC cycles starting the cycle after the push.
    push(32'h100, 32'hDEAD_BEEF);
    n = 0;
    for (int i = 1; i <= 6; i++) begin
      idle();
      if (bus.mem_write_en) n++;
      if (i == 1) begin
        chk("single_we_first", bus.mem_write_en, 1'b1);
        chk("single_addr", bus.mem_addr, 32'h100);
        chk("single_data", bus.mem_data_in, 32'hDEAD_BEEF);
      end
      if (i == 5) chk("single_empty_after", bus.empty, 1'b1);
    end
    chk("single_we_cycles", n, 4);

    // Five back-to-back stores: the fifth waits for the first pop.
    wr_log.delete();
    for (int i = 0; i < 5; i++) begin
      a5[i] = 32'h1000 + 32'(16 * i);
      d5[i] = $urandom;
    end
    k = 0;
    refused_at = -1;
    for (int c = 0; c < 40 && k < 5; c++) begin
      push(a5[k], d5[k]);
      if (bus.wr_ready) begin
        acc_at[k] = c;
        k++;
      end else if (refused_at < 0) begin
        refused_at = c;
      end
    end
    idle();
    chk("full_refused_cycle", refused_at, 4);
    chk("full_fifth_accept_cycle", acc_at[4], 5);
    wait_empty("full_drained");
    chk("full_write_count", wr_log.size(), 5);
    for (int i = 0; i < 5 && i < wr_log.size(); i++) chk("full_write_order", wr_log[i], a5[i]);

    // Read hit forwards the youngest of two stores to the same word.
    push(32'h200, 32'hAAAA_0001);
    push(32'h200, 32'hBBBB_0002);
    drive(1'b1, 1'b0, '0, '0, 1'b1, 32'h200);
    chk("hit_no_early_valid", bus.rd_valid, 1'b0);
    idle();
    chk("hit_rd_valid", bus.rd_valid, 1'b1);
    chk("hit_rd_data", bus.rd_data, 32'hBBBB_0002);
    n = 0;
    for (int i = 0; i < 40 && !bus.empty; i++) begin
      if (!bus.mem_write_en && bus.mem_addr != 0) n++;
      idle();
    end
    chk("hit_no_read_cycles", n, 0);
    wait_empty("hit_drained");

    // Read miss during a write waits for it, then the remaining store drains.
    push(32'h400, 32'h1111_2222);
    push(32'h404, 32'h3333_4444);
    drive(1'b1, 1'b0, '0, '0, 1'b1, 32'h300);
    for (int c = 3; c <= 11; c++) begin
      idle();
      if (c == 4) chk("miss_write_holds", bus.mem_addr, 32'h400);
      if (c == 5) chk("miss_gap_we", bus.mem_write_en, 1'b0);
      if (c == 6 || c == 9) begin
        chk("miss_read_we", bus.mem_write_en, 1'b0);
        chk("miss_read_addr", bus.mem_addr, 32'h300);
      end
      if (c == 10) begin
        chk("miss_rd_valid", bus.rd_valid, 1'b1);
        chk("miss_rd_data", bus.rd_data, mem_fn(32'h300));
      end
      if (c == 11) chk("miss_next_write", bus.mem_addr, 32'h404);
    end
    wait_empty("miss_drained");

    // Reset in the middle of the second write with three entries held.
    for (int i = 0; i < 4; i++) push(32'h500 + 32'(4 * i), $urandom);
    idle();
    idle();
    idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    chk("rst_mid_we_before", bus.mem_write_en, 1'b1);
    chk("rst_mid_addr_before", bus.mem_addr, 32'h504);
    idle();
    chk("rst_we_after", bus.mem_write_en, 1'b0);
    chk("rst_empty_after", bus.empty, 1'b1);
    chk("rst_ready_after", bus.wr_ready, 1'b1);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      idle();
      if (bus.mem_write_en) n++;
    end
    chk("rst_no_writes", n, 0);

    // Random traffic over a small address window so hits, misses and full stalls all occur.
    for (int c = 0; c < 3000; c++) begin
      wv = ($urandom_range(0, 99) < 45);
      wa = 32'h800 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      rq = ($urandom_range(0, 99) < 12);
      ra = 32'h800 + 32'(4 * $urandom_range(0, 9)) + 32'($urandom_range(0, 3));
      rb = ($urandom_range(0, 599) != 0);
      drive(rb, wv, wa, $urandom, rq, ra);
    end
    idle();
    wait_empty("random_drained");
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/write_buffer.md
WRITE_BUFFER -- requirements
Module: write_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered store entries (power of two, 2..16).
REQ-002 Parameter MEM_CYCLES, default 4, cycles main memory needs per read or write access (1..15).
REQ-003 One clock; reset is synchronous and active-low; ports are named clk and rst_b.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_b  input  1  synchronous active-low reset.
REQ-006 wr_valid  input  1  cache presents a store.
REQ-007 wr_ready  output  1  buffer accepts the store this cycle.
REQ-008 wr_addr  input  32  store byte address; word-aligned, bits [1:0] ignored.
REQ-009 wr_data  input  4x8  store data, byte [0] is MSB.
REQ-010 rd_req  input  1  single-cycle read-miss request from the cache.
REQ-011 rd_addr  input  32  read address, sampled only when rd_req=1.
REQ-012 rd_valid  output  1  one-cycle pulse: rd_data is valid.
REQ-013 rd_data  output  4x8  returned read word.
REQ-014 mem_addr  output  32  address to main memory.
REQ-015 mem_data_in  output  4x8  write data to main memory.
REQ-016 mem_data_out  input  4x8  read data from main memory.
REQ-017 mem_write_en  output  1  main-memory write strobe.
REQ-018 empty  output  1  no stores buffered and no write in flight.

Function
REQ-019 Push occurs when wr_valid=1 and wr_ready=1; wr_ready=1 iff the registered entry count < DEPTH.
REQ-020 A simultaneous push and pop leaves the count unchanged; entries drain in FIFO order; pointers wrap modulo DEPTH.
REQ-021 FSM states IDLE, WRITE, READ; IDLE->READ if a read is pending, else IDLE->WRITE if count>0; reads take priority over starting a new write.
REQ-022 WRITE: mem_write_en=1, mem_addr/mem_data_in = head entry, held constant for exactly MEM_CYCLES cycles; the head is popped on the last cycle; then IDLE.
REQ-023 READ: mem_write_en=0, mem_addr = latched rd_addr for MEM_CYCLES cycles; mem_data_out is captured into rd_data on the last cycle; rd_valid pulses the next cycle; then IDLE.
REQ-024 At the rd_req cycle, the buffered entries are compared on addr[31:2]; on a hit, rd_data = youngest matching entry and rd_valid pulses the next cycle, with no memory access.
REQ-025 A miss is latched as pending; it is never forwarded from stores pushed after the rd_req cycle.
REQ-026 A miss arriving during WRITE waits until that write completes; the write is never aborted.
REQ-027 Only one read is outstanding; rd_req is ignored while a read is pending or in READ.
REQ-028 Outside WRITE and READ: mem_write_en=0, mem_addr=0, mem_data_in=0.
REQ-029 empty=1 iff count=0 and state is not WRITE.

Reset
REQ-030 While rst_b=0 at the clock edge, the following take their reset values: count=0, pointers=0, state=IDLE, pending read cleared, rd_valid=0, rd_data=0, mem_write_en=0, mem_addr=0, mem_data_in=0, empty=1.
REQ-031 Reset mid-operation discards all entries and any in-flight access; mem_write_en is 0 from the first cycle after the reset edge.

Structure
REQ-032 Shared package wb_pkg holds the word_bytes_t (4x8) typedef, the state enum, and the DEPTH and MEM_CYCLES defaults.
REQ-033 One sub-module, wb_fifo, holds entry storage, pointers, count and the youngest-match address lookup; the FSM and memory muxing live in write_buffer.

Verification
REQ-034 Push 0x100/{DE,AD,BE,EF} into an idle buffer -> mem_write_en=1 for exactly 4 cycles starting the next cycle, mem_addr=0x100, then empty=1.
REQ-035 Push 5 stores back-to-back from empty -> wr_ready=0 on the 5th attempt (count=4); the 5th store is accepted after the first pop, and memory writes occur in push order.
REQ-036 Push 0x200/A, then 0x200/B, then rd_req 0x200 -> rd_valid the next cycle with rd_data=B, and no READ state is entered.
REQ-037 rd_req 0x300 (miss) on the 2nd cycle of a write -> READ starts after the 4th write cycle, mem_addr=0x300, rd_valid carries mem_data_out, then remaining stores drain.
REQ-038 rst_b=0 on the 2nd cycle of a write with 3 entries -> mem_write_en=0, empty=1, wr_ready=1 the next cycle, and no further memory writes.
